uart_tx_scheduler: RTL
======================

# uart_tx_scheduler

- Two-port UART transmit scheduler.
- Arbitrates between two byte requesters with round-robin priority.
- Serialises the granted byte onto a single `tx` line, timed by the 16x-oversampling `tick` pulse from the baud rate generator.
- Sits between the baud rate generator (`tick` source) and the byte producers sharing the one UART output pin.

## Interface
- `DATA_BITS`, default 8: data bits per frame, LSB first; legal range 5–8.
- `clk` input 1: system clock; all state changes on rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `tick` input 1: one-`clk`-wide pulse at 16x baud rate from the baud rate generator.
- `req0` input 1: port 0 request; held high with `data0` stable until `ack0`.
- `data0` input `DATA_BITS`: port 0 byte.
- `ack0` output 1: one-cycle pulse; `data0` captured.
- `req1` input 1: port 1 request; held high with `data1` stable until `ack1`.
- `data1` input `DATA_BITS`: port 1 byte.
- `ack1` output 1: one-cycle pulse; `data1` captured.
- `tx` output 1: serial line; idle high.
- `busy` output 1: high while a frame is in progress (state ≠ IDLE).
- `grant_id` output 1: port of the current or most recent frame.

## Operation
- **States:** IDLE, START, DATA, PARITY (only with the macro defined), STOP.
- **Reset values:** `tx`=1, `ack0`=`ack1`=0, `busy`=0, `grant_id`=0, state IDLE, round-robin pointer favours port 0, tick counter 0, bit index 0.
- **Arbitration** (IDLE only, on a `clk` edge with `tick`=1):
  - Exactly one request present: grant that port.
  - Both present: grant the pointer's port.
  - After every grant, the pointer moves to the other port.
  - Requests seen on non-tick cycles wait; requests are never dropped.
- **On grant:**
  - Shift register ← granted data.
  - `ackN`=1 for exactly one cycle.
  - `grant_id` ← N.
  - `tx` ← 0, state START, tick counter ← 0.
- **Tick counter:**
  - Increments on each `tick` while not IDLE.
  - At count 15 with `tick`, the bit ends and the counter wraps to 0.
  - Each bit is exactly 16 tick periods.
- **Bit sequence:**
  - START end: state DATA, `tx` ← shift[0], bit index 0.
  - DATA: at each bit end, shift right; `tx` ← next LSB.
  - After bit `DATA_BITS`-1 ends: state STOP (or PARITY), `tx` ← 1 (or parity).
- **STOP end:** state IDLE, `tx` stays 1. The earliest next grant is on the following tick, giving a 1-tick idle gap between back-to-back frames.
- **Request and data hold:**
  - `req` deassertion before ack is allowed; that port is simply not granted.
  - `req`/data changes after ack do not affect the frame in progress.
- **Asynchronous reset mid-frame:** all outputs go to reset values immediately, the frame is aborted, and no ack is reissued.

## Timing
- Grant-to-`tx` latency: `tx` falls on the grant edge, in the same cycle as `ackN`.
- Frame length: (2 + `DATA_BITS`) × 16 tick periods, or (3 + `DATA_BITS`) × 16 with parity.
- `busy` rises with `ackN` and falls on the edge where STOP ends.
- `ack0` and `ack1` are never high in the same cycle.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state is inserted between DATA and STOP, lasting 16 ticks.
  - `tx` = even parity, i.e. the XOR of the captured data bits.
- `UART_TX_PARITY_EN` undefined:
  - No PARITY state; DATA goes directly to STOP.
  - No parity logic is synthesised.

## Test plan
- **Single request, no parity** (`tick` every 4 `clk`): `req0`=1, `data0`=0x55.
  - `ack0` pulses for one cycle on the first tick edge.
  - `tx` = 0,1,0,1,0,1,0,1,0,1, each bit 64 `clk`.
  - `busy` is high for 640 `clk`; `grant_id`=0.
- **Simultaneous requests after reset:** `data0`=0xA3, `data1`=0x3C, both asserted in the same cycle.
  - Port 0 is served first.
  - Port 1 is granted on the first tick after STOP ends; `grant_id`=1.
- **Sustained contention:** `req0` and `req1` held high for 4 frames.
  - Grants alternate 0,1,0,1.
  - Every frame is followed by exactly a 1-tick idle gap.
- **Off-tick request:** `req1` asserted 2 `clk` after a tick.
  - `ack1` waits for the next tick; no ack occurs on non-tick cycles.
- **Reset mid-frame:** `rst_n` pulled low during DATA bit 3.
  - `tx`=1 and `busy`=0 immediately, with no `clk` edge needed.
  - After release, with `req0` still high, the frame restarts with a new `ack0`.
- **Parity** (`UART_TX_PARITY_EN` defined): `data0`=0x07.
  - The parity bit is 1; the frame is 11 bits (176 ticks).
  - `data0`=0x03 gives a parity bit of 0.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_scheduler
// Purpose  : Round-robin arbiter for two byte producers. It serialises the
//            granted byte onto one UART tx line, timed by a 16x tick.
//            Optional even-parity bit: define UART_TX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 req0,
    input  logic [DATA_BITS-1:0] data0,
    output logic                 ack0,
    input  logic                 req1,
    input  logic [DATA_BITS-1:0] data1,
    output logic                 ack1,
    output logic                 tx,
    output logic                 busy,
    output logic                 grant_id
);

    localparam int                 IDX_W  = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0]   C_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t                 r_state, w_state;
    logic [3:0]             r_cnt, w_cnt;
    logic [IDX_W-1:0]       r_idx, w_idx;
    logic [DATA_BITS-1:0]   r_shift, w_shift;
    logic                   r_tx, w_tx;
    logic                   r_ack0, w_ack0;
    logic                   r_ack1, w_ack1;
    logic                   r_gid, w_gid;
    logic                   r_ptr, w_ptr;
`ifdef UART_TX_PARITY_EN
    logic                   r_par, w_par;
`endif

    logic                   w_gnt0, w_gnt1, w_bit_end;
    logic [DATA_BITS-1:0]   w_sel_data;

    // r_ptr = 0 favours port 0 when both ports request together
    assign w_gnt0     = req0 && (!req1 || !r_ptr);
    assign w_gnt1     = req1 && (!req0 ||  r_ptr);
    assign w_sel_data = w_gnt1 ? data1 : data0;
    assign w_bit_end  = tick && (r_cnt == 4'd15);

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_idx   = r_idx;
        w_shift = r_shift;
        w_tx    = r_tx;
        w_ack0  = 1'b0;
        w_ack1  = 1'b0;
        w_gid   = r_gid;
        w_ptr   = r_ptr;
`ifdef UART_TX_PARITY_EN
        w_par   = r_par;
`endif
        if (r_state != S_IDLE && tick) begin
            w_cnt = r_cnt + 4'd1;
        end
        case (r_state)
            S_IDLE: begin
                if (tick && (w_gnt0 || w_gnt1)) begin
                    w_state = S_START;
                    w_cnt   = 4'd0;
                    w_idx   = '0;
                    w_tx    = 1'b0;
                    w_shift = w_sel_data;
                    w_gid   = w_gnt1;
                    w_ptr   = ~w_gnt1;
                    w_ack0  = w_gnt0;
                    w_ack1  = w_gnt1;
`ifdef UART_TX_PARITY_EN
                    w_par   = ^w_sel_data;
`endif
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state = S_DATA;
                    w_tx    = r_shift[0];
                    w_idx   = '0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_idx == C_LAST) begin
`ifdef UART_TX_PARITY_EN
                        w_state = S_PARITY;
                        w_tx    = r_par;
`else
                        w_state = S_STOP;
                        w_tx    = 1'b1;
`endif
                    end else begin
                        w_shift = r_shift >> 1;
                        w_tx    = r_shift[1];
                        w_idx   = r_idx + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state = S_STOP;
                    w_tx    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    w_state = S_IDLE;
                    w_tx    = 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_tx    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_gid   <= 1'b0;
            r_ptr   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_idx   <= w_idx;
            r_shift <= w_shift;
            r_tx    <= w_tx;
            r_ack0  <= w_ack0;
            r_ack1  <= w_ack1;
            r_gid   <= w_gid;
            r_ptr   <= w_ptr;
`ifdef UART_TX_PARITY_EN
            r_par   <= w_par;
`endif
        end
    end

    assign tx       = r_tx;
    assign ack0     = r_ack0;
    assign ack1     = r_ack1;
    assign grant_id = r_gid;
    assign busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire
